// File: rtl/serial_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : serial_alu_sequencer
// Description : Bit-serial initiator for the 1-bit ALU slice. Accepts a
//               WIDTH-bit request, drives the slice one bit per cycle (LSB
//               first) with the carry chained through a register, and returns
//               the WIDTH-bit result over a valid/ready handshake.
//               Optional feature macro: SERIAL_ALU_OVF_EN (adds resp_ovf).
// Revision    : 1.0 - initial release
// ============================================================================
module serial_alu_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    // request channel
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_a,
    input  logic [WIDTH-1:0] req_b,
    input  logic             req_cin,
    input  logic [2:0]       req_op,
    // response channel
    output logic             resp_valid,
    input  logic             resp_ready,
    output logic [WIDTH-1:0] resp_result,
    output logic             resp_cout,
`ifdef SERIAL_ALU_OVF_EN
    output logic             resp_ovf,
`endif
    // slice interface
    output logic             slice_A,
    output logic             slice_B,
    output logic             slice_Cin,
    output logic [2:0]       slice_ALUOp,
    input  logic             slice_Result,
    input  logic             slice_Cout
);

    localparam int c_IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_IW-1:0] c_LAST = c_IW'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SUB = 3'b110;
    localparam logic [2:0] c_OP_SLT = 3'b111;

    logic [1:0]       r_state;
    logic [WIDTH-1:0] r_a;        // operand A, shifted right one bit per RUN cycle
    logic [WIDTH-1:0] r_b;        // operand B, shifted right one bit per RUN cycle
    logic [2:0]       r_op;
    logic [c_IW-1:0]  r_idx;
    logic [WIDTH-1:0] r_res;      // result, filled from the MSB end so bit 0 lands last at [0]
    logic             r_carry;    // carry into the next bit; final carry out once DONE
    logic             r_cmsb;     // carry into the MSB, kept for signed overflow

    logic             w_run;
    logic             w_done;
    logic             w_is_sub;
    logic             w_is_arith;
    logic             w_carry_init;
    logic             w_ovf;
    logic [WIDTH-1:0] w_slt_word;

    assign w_run      = (r_state == c_RUN);
    assign w_done     = (r_state == c_DONE);
    assign w_is_sub   = (r_op == c_OP_SUB) || (r_op == c_OP_SLT);
    assign w_is_arith = (r_op == c_OP_ADD) || w_is_sub;
    assign w_ovf      = r_cmsb ^ r_carry;

    assign req_ready  = (r_state == c_IDLE);
    assign resp_valid = w_done;

    // Carry preloaded at accept: ADD uses req_cin, SUB/SLT form a + ~b + 1
    always_comb begin
        w_carry_init = 1'b0;
        case (req_op)
            c_OP_ADD:          w_carry_init = req_cin;
            c_OP_SUB, c_OP_SLT: w_carry_init = 1'b1;
            default:           w_carry_init = 1'b0;
        endcase
    end

    // Slice drive: idle-quiet outside RUN; subtraction issued as ADD with inverted B
    always_comb begin
        slice_A     = 1'b0;
        slice_B     = 1'b0;
        slice_Cin   = 1'b0;
        slice_ALUOp = 3'b000;
        if (w_run) begin
            slice_A = r_a[0];
            if (w_is_arith) begin
                slice_ALUOp = c_OP_ADD;
                slice_B     = w_is_sub ? ~r_b[0] : r_b[0];
                slice_Cin   = r_carry;
            end else begin
                slice_ALUOp = r_op;
                slice_B     = r_b[0];
            end
        end
    end

    // Sequencer state, operand shifters, result capture and carry chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_IDLE;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= 3'b000;
            r_idx   <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            r_cmsb  <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (req_valid) begin
                        r_a     <= req_a;
                        r_b     <= req_b;
                        r_op    <= req_op;
                        r_idx   <= '0;
                        r_res   <= '0;
                        r_carry <= w_carry_init;
                        r_cmsb  <= 1'b0;
                        r_state <= c_RUN;
                    end
                end
                c_RUN: begin
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_res   <= {slice_Result, r_res[WIDTH-1:1]};
                    r_carry <= slice_Cout;
                    if (r_idx == c_LAST) begin
                        r_cmsb  <= slice_Cin;
                        r_state <= c_DONE;
                    end else begin
                        r_idx <= r_idx + c_IW'(1);
                    end
                end
                c_DONE: begin
                    if (resp_ready) begin
                        r_state <= c_IDLE;
                    end
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

    // Response word: SLT collapses to sign-of-difference corrected for overflow
    always_comb begin
        w_slt_word    = '0;
        w_slt_word[0] = r_res[WIDTH-1] ^ w_ovf;
        resp_result   = '0;
        resp_cout     = 1'b0;
        if (w_done) begin
            case (r_op)
                c_OP_ADD, c_OP_SUB: begin
                    resp_result = r_res;
                    resp_cout   = r_carry;
                end
                c_OP_SLT: resp_result = w_slt_word;
                default:  resp_result = r_res;
            endcase
        end
    end

`ifdef SERIAL_ALU_OVF_EN
    // Signed overflow is reported only for ADD and SUB
    always_comb begin
        resp_ovf = 1'b0;
        if (w_done && ((r_op == c_OP_ADD) || (r_op == c_OP_SUB))) begin
            resp_ovf = w_ovf;
        end
    end
`else
`endif

endmodule
`default_nettype wire
